updown_mod_counter: RTL
=======================

# updown_mod_counter

Parametrised synchronous up/down counter with a programmable modulus, parallel load, count enable, wrap or saturate behaviour, and a ripple-carry output for cascading. It is the general-purpose successor to the team's 4-bit loadable up/down counter. It sits in timer, prescaler and BCD/decade display chains, where several instances are cascaded by feeding one stage's `rco` into the next stage's `en`.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits.
- `MODULUS`, default 256: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH; illegal values are a build-time error.

Ports (clock and reset first):
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-low.
- `en`  input  1  count enable; also the cascade input from a lower stage's `rco`.
- `mode`  input  1  count direction: 1 = up, 0 = down.
- `sat`  input  1  terminal behaviour: 0 = wrap, 1 = saturate (hold at terminal).
- `load`  input  1  synchronous parallel load.
- `data`  input  WIDTH  load value.
- `count`  output  WIDTH  registered count value.
- `rco`  output  1  combinational ripple carry/borrow out.
- `wrap`  output  1  registered one-cycle pulse following a wrap event.
- `at_max`  output  1  combinational flag: `count == MODULUS-1`.
- `at_zero`  output  1  combinational flag: `count == 0`.

## Operation
- **Terminal value:** MODULUS-1 when `mode=1`; 0 when `mode=0`. `term` = (`count` == terminal value for the current `mode`).
- **Priority per rising edge:** reset > load > count > hold.
  - **Reset** (`rst=0`): `count` ← 0 and `wrap` ← 0. Reset overrides `load` and `en`. Asserting reset mid-count aborts the count with no wrap pulse.
  - **Load** (`load=1`): `count` ← `data`. If `data` ≥ MODULUS, `count` ← MODULUS-1 (clamped). Load is independent of `en`. Load never produces `wrap`.
  - **Count** (`en=1`, `load=0`):
    - If not `term`: `count` ← `count`+1 (up) or `count`−1 (down).
    - If `term` and `sat=0`: `count` wraps (up: MODULUS-1→0; down: 0→MODULUS-1) and `wrap` ← 1 on the same edge.
    - If `term` and `sat=1`: `count` holds.
  - **Hold** (`en=0`, `load=0`): `count` holds.
- **`wrap`** is 0 on every edge that does not perform a wrap. A wrap on every cycle keeps `wrap` high continuously.
- **`rco`** = `en` & ~`load` & `term`. It is asserted in saturate mode as well.
- **Cascading:** stage N+1's `en` = stage N's `rco`. The higher stage then steps exactly on the edge the lower stage wraps.
- **Direction change:** changing `mode` takes effect on the next edge. `term` and `rco` re-evaluate combinationally within the same cycle.
- **Arithmetic:** all arithmetic is modulo MODULUS, never modulo 2^WIDTH. `count` never holds a value ≥ MODULUS.
- **Inputs:** `data` is ignored when `load=0`. `mode` and `sat` are don't-care when `en=0` and `load=0`.

## Timing
- `count` latency is one cycle: an input sampled at edge k is visible on `count` after edge k.
- `rco`, `at_max` and `at_zero` are purely combinational from `count`, `en`, `load` and `mode`. There is no register stage on these outputs.
- `wrap` asserts in the cycle after the wrapping edge and lasts one cycle per wrap.
- Reset values after the first edge with `rst=0`: `count`=0, `wrap`=0, `at_zero`=1, `at_max`=0.
  - `rco` = `en` & ~`load` & ~`mode`, because a down-counter sits at its terminal value of 0.
- Cascade ripple: N stages give N combinational `rco`→`en` levels. Clock frequency is limited by this chain and is the integrator's responsibility.

## Test plan
- **Reset:** with WIDTH=4, MODULUS=10, drive `rst=0` while `load=1`, `data=7` → `count`=0, `wrap`=0, `at_zero`=1. Release reset, `mode=1`, `en=1` for 3 cycles → `count` steps 1, 2, 3.
- **Up wrap:** `load` 8, then `mode=1`, `sat=0`, `en=1` → `count` 9, 0, 1. `rco`=1 only while `count`=9. `wrap`=1 only in the cycle `count`=0.
- **Down wrap and saturate:** `load` 1, `mode=0`, `sat=0` → `count` 0, 9. Then `sat=1` at `count`=0 → `count` holds at 0, `rco` stays 1, `wrap` stays 0.
- **Load priority and clamp:** `load=1`, `en=1`, `data=13` with MODULUS=10 → `count`=9, `rco`=0 during the load, no `wrap`. Then `load=0`, `en=0` → `count` holds at 9.
- **Cascade:** two instances with MODULUS=10, `mode=1`, low stage `en=1` tied high → after 23 cycles from reset the high/low pair reads 2/3. The high stage increments exactly on each low-stage 9→0 edge.
- **Mid-count reset and direction flip:** counting up at 5, flip to `mode=0` → next edge `count`=4. Assert `rst=0` for one edge → `count`=0 and no `wrap` pulse.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Parametrised up/down counter with programmable modulus, parallel load,
// wrap-or-saturate terminal behaviour and a ripple-carry output for cascading.
module updown_mod_counter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MODULUS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             rco,
    output logic             wrap,
    output logic             at_max,
    output logic             at_zero
);

    localparam int unsigned EXT_W = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2 || 64'(MODULUS) > (64'(1) << WIDTH)) begin : g_bad_modulus
            $error("updown_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    logic             term;
    logic [WIDTH-1:0] load_val;

    assign at_max  = (count == MAX_VAL);
    assign at_zero = (count == '0);
    assign term    = mode ? at_max : at_zero;
    assign rco     = en & ~load & term;

    // Out-of-range load values clamp to the top of the count range.
    assign load_val = ({1'b0, data} >= EXT_W'(MODULUS)) ? MAX_VAL : data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= load_val;
            end else if (en) begin
                if (!term) begin
                    count <= mode ? (count + WIDTH'(1)) : (count - WIDTH'(1));
                end else if (!sat) begin
                    count <= mode ? '0 : MAX_VAL;
                    wrap  <= 1'b1;
                end
            end
        end
    end

endmodule
